// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default parameter values and the event-counter width.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_seq_state_e;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_SYNC_DEPTH = 2;
  localparam int DEF_MIN_ASSERT = 16;
  localparam int DEF_STAGGER    = 4;
  localparam int EVT_CNT_W      = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_req_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous reset request,
// with a synchronous active-high clear.
module rst_req_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_DEPTH-1:0] r_stages;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_stages[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches synchronized reset requests, then releases the
// downstream channel resets one at a time in ascending order.
// Optional feature: define RST_SEQ_EVT_CNT_EN to add the evt_cnt event counter.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
  parameter int MIN_ASSERT = DEF_MIN_ASSERT,
  parameter int STAGGER    = DEF_STAGGER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] rst_req,
  output logic [N_CH-1:0] ch_rst,
  output logic            ready
`ifdef RST_SEQ_EVT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

  localparam int CNT_W = $clog2(max2(MIN_ASSERT, STAGGER)) + 1;
  localparam int IDX_W = $clog2(N_CH) + 1;

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("reset_sequencer: N_CH must be in 1..32");
  end
  if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
    $error("reset_sequencer: SYNC_DEPTH must be >= 2");
  end
  if (MIN_ASSERT < 1) begin : g_bad_min_assert
    $error("reset_sequencer: MIN_ASSERT must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER must be >= 1");
  end

  logic [N_CH-1:0]  w_req_sync;
  logic [N_CH-1:0]  w_rel_mask;
  logic             w_req_s;

  rst_seq_state_e   r_state;
  logic [N_CH-1:0]  r_ch_rst;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    rst_req_sync #(
      .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
      .clk     (clk),
      .i_clr   (rst),
      .i_async (rst_req[gi]),
      .o_sync  (w_req_sync[gi])
    );
    // one-hot select of the channel due for release
    assign w_rel_mask[gi] = (r_idx == IDX_W'(gi));
  end

  assign w_req_s = |w_req_sync;

  always_ff @(posedge clk) begin
    if (rst || w_req_s) begin
      r_state  <= ST_ASSERT;
      r_ch_rst <= '1;
      r_ready  <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      unique case (r_state)
        ST_ASSERT: begin
          if (r_cnt == CNT_W'(MIN_ASSERT - 1)) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(STAGGER - 1)) begin
            r_ch_rst <= r_ch_rst & ~w_rel_mask;
            r_cnt    <= '0;
            if (r_idx == IDX_W'(N_CH - 1)) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_ch_rst <= '0;
          r_ready  <= 1'b1;
        end
        default: begin
          r_state  <= ST_ASSERT;
          r_ch_rst <= '1;
          r_ready  <= 1'b0;
          r_cnt    <= '0;
          r_idx    <= '0;
        end
      endcase
    end
  end

  assign ch_rst = r_ch_rst;
  assign ready  = r_ready;

`ifdef RST_SEQ_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] r_evt_cnt;
  logic                 r_req_s_d;

  // counts rising edges of the combined request, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_cnt <= '0;
      r_req_s_d <= 1'b0;
    end else begin
      r_req_s_d <= w_req_s;
      if (w_req_s && !r_req_s_d && (r_evt_cnt != '1)) begin
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
    end
  end

  assign evt_cnt = r_evt_cnt;
`endif

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of sequenced reset channels (1..32).
REQ-002 SHALL have parameter SYNC_DEPTH, default 2, flop stages per request synchronizer (>=2).
REQ-003 SHALL have parameter MIN_ASSERT, default 16, minimum cycles all channels are held in reset after requests clear (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, cycles between consecutive channel releases (>=1).
REQ-005 SHALL have port: clk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port: rst_req  in  N_CH  asynchronous active-high reset requests from other domains, one per source.
REQ-008 SHALL have port: ch_rst  out  N_CH  active-high synchronous reset to each downstream channel.
REQ-009 SHALL have port: ready  out  1  high only when all ch_rst bits are released.
REQ-010 SHALL have port: evt_cnt  out  8  reset-request event count (present only with RST_SEQ_EVT_CNT_EN).

Function
REQ-011 SHALL synchronize each rst_req bit through SYNC_DEPTH flops; req_s = OR of the synchronized bits.
REQ-012 SHALL implement FSM states ASSERT, RELEASE, RUN; one cycle counter; one channel index.
REQ-013 In ASSERT: ch_rst all 1, ready 0; counter increments each cycle req_s=0, clears to 0 each cycle req_s=1 (pulse stretching).
REQ-014 ASSERT->RELEASE on the edge where counter==MIN_ASSERT-1 and req_s=0; counter and index cleared.
REQ-015 In RELEASE: on the edge where counter==STAGGER-1, ch_rst[index] cleared, index incremented, counter cleared; channels release strictly in ascending order 0..N_CH-1.
REQ-016 RELEASE->RUN on the same edge that clears ch_rst[N_CH-1]; ready rises on that edge.
REQ-017 In RUN: ch_rst all 0, ready 1, counter idle.
REQ-018 req_s=1 in RELEASE or RUN SHALL force ASSERT on the next edge: ch_rst all 1, ready 0, counter and index 0.
REQ-019 With defaults, ch_rst[k] SHALL fall 16+4*(k+1) edges after the first cycle in ASSERT with req_s=0; ready rises with ch_rst[3] at edge 32.
REQ-020 Once released, a channel SHALL remain released until the next ASSERT; no glitches on ch_rst (registered outputs only).

Reset
REQ-021 rst SHALL take priority over all other events in the same cycle.
REQ-022 On rst: state ASSERT, ch_rst all 1, ready 0, counter 0, index 0, synchronizer flops 0, evt_cnt 0.
REQ-023 rst mid-RELEASE SHALL re-assert already released channels on the next edge and restart the full sequence.

Configuration
REQ-024 Macro RST_SEQ_EVT_CNT_EN defined: evt_cnt present; increments by 1 on each 0->1 transition of req_s; saturates at 255; cleared only by rst.
REQ-025 Macro undefined: evt_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-026 Package rst_seq_pkg SHALL hold the FSM state enum, default parameter constants and EVT_CNT_W=8.
REQ-027 Sub-module rst_req_sync SHALL implement one SYNC_DEPTH-stage synchronizer with synchronous active-high clear; instantiated N_CH times via generate.
REQ-028 Counter width SHALL be $clog2(max(MIN_ASSERT,STAGGER))+1; index width $clog2(N_CH)+1.
REQ-029 Illegal parameter values SHALL be rejected with an elaboration-time assertion.

Verification
REQ-030 rst held 5 cycles then released, no requests -> ch_rst=4'b1111 until edge 20; 4'b1110 at 20, 1100 at 24, 1000 at 28, 0000 and ready=1 at 32.
REQ-031 In RUN, rst_req[2] pulsed 1 cycle -> ch_rst=1111, ready=0 SYNC_DEPTH+1 edges later; full 32-edge sequence follows.
REQ-032 rst_req[0] held high 50 cycles -> ch_rst stays 1111 throughout; release sequence starts only after synchronized deassertion.
REQ-033 rst_req[1] asserted while ch_rst=1100 -> next edge after req_s rises gives ch_rst=1111, index restarts at 0.
REQ-034 rst asserted in the same cycle as req_s rising in RUN -> reset state; evt_cnt=0 (macro on).
REQ-035 Macro on: 300 separated request pulses -> evt_cnt saturates at 255; macro off: design elaborates without evt_cnt, REQ-030 timing unchanged.
